// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port synchronous 4096x16 memory with a one-cycle registered read.
// It accepts single-word or burst commands and returns read words as a valid-qualified stream.
module mem_burst_master #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [ADDR_BITS-1:0] req_len,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 wdata_valid,
  output logic                 wdata_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 done,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] mem_adress,
  output logic                 mem_write,
  output logic [DATA_BITS-1:0] mem_indata,
  input  logic [DATA_BITS-1:0] mem_outdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   adr_q, adr_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  logic                   rdValid_q, rdValid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      cnt_q     <= '0;
      rdValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
      rdValid_q <= rdValid_d;
    end
  end

  // cnt holds words remaining minus one, so cnt==0 marks the final word of the burst.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    rdValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d   = req_addr;
          cnt_d   = req_len;
          state_d = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          adr_d = adr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        rdValid_d = 1'b1;
        adr_d     = adr_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory strobes stay combinational from state so an async reset drops mem_write at once.
  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign wdata_ready = (state_q == WRITE);
  assign mem_write   = (state_q == WRITE) && wdata_valid;
  assign mem_indata  = wdata;
  assign mem_adress  = adr_q;
  assign rd_valid    = rdValid_q;
  assign rd_data     = mem_outdata;

endmodule
